// File: rtl/multicycle_ctrl_if.sv
// Instruction-memory fetch interface for the multicycle control unit.
// Carries the ready/request handshake and the 16-bit instruction word.
//   imem_req   : control unit -> memory, fetch request (high only while fetching)
//   imem_ready : memory -> control unit, instruction word is valid this cycle
//   instr      : memory -> control unit, 16-bit instruction word
// The master modport is used by the control unit; the slave modport by the memory side.
interface multicycle_ctrl_if;
  logic        imem_req;
  logic        imem_ready;
  logic [15:0] instr;

  modport master (
    output imem_req,
    input  imem_ready,
    input  instr
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    output instr
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the 8-bit processor datapath (16-entry regfile,
// PC register with next-PC mux4, write-data mux2, ALU and zero-flag ffd).
// Fetches a 16-bit instruction over the imem interface into an internal IR,
// then spends one cycle in DECODE and one in EXEC, where all strobes fire.
// Ports:
//   clk, reset         : clock (rising edge), asynchronous active-low reset
//   imem               : fetch handshake (imem_req out, imem_ready/instr in)
//   z                  : current zero flag from the flag ffd
//   ra1, ra2, wa3      : regfile addresses decoded from IR
//   imm, target        : immediate and jump target decoded from IR
//   alu_op             : ALU operation decoded from IR
//   we3, wd3_src       : regfile write enable and write-data mux select
//   z_load             : zero-flag load enable
//   pc_we, pc_src      : PC load enable and next-PC mux select
//   halted, fault      : levels for the HALT and FAULT absorbing states
//   illegal            : one-cycle pulse on an illegal opcode
module multicycle_ctrl #(
  parameter int PC_WIDTH      = 10,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_ctrl_if.master   imem,
  input  logic                z,
  output logic [3:0]          ra1,
  output logic [3:0]          ra2,
  output logic [3:0]          wa3,
  output logic [7:0]          imm,
  output logic [PC_WIDTH-1:0] target,
  output logic [2:0]          alu_op,
  output logic                we3,
  output logic                wd3_src,
  output logic                z_load,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                halted,
  output logic                fault,
  output logic                illegal
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT,
    FAULT
  } state_t;

  // The miss that brings the counter up to FETCH_TIMEOUT is the one that faults.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;
  logic [7:0]  miss_cnt;
  logic [3:0]  opcode;

  // IR fields are plain wiring; IR is cleared by reset so every field reads 0 then.
  assign opcode = ir[15:12];
  assign ra1    = ir[7:4];
  assign ra2    = ir[3:0];
  assign wa3    = ir[11:8];
  assign imm    = ir[7:0];
  assign target = ir[PC_WIDTH-1:0];
  assign alu_op = ir[14:12];

  assign imem.imem_req = (state == FETCH);
  assign halted        = (state == HALT);
  assign fault         = (state == FAULT);

  // State register, instruction capture and fetch-miss counter. The IR only
  // loads on a completed handshake, so instr is ignored in every other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ir       <= 16'h0000;
      miss_cnt <= 8'd0;
    end else begin
      state <= next_state;
      if (state == FETCH && imem.imem_ready) begin
        ir <= imem.instr;
      end
      if (state == FETCH && !imem.imem_ready) begin
        miss_cnt <= miss_cnt + 8'd1;
      end else begin
        miss_cnt <= 8'd0;
      end
    end
  end

  // Next-state and strobe decode. Strobes default low and are only raised in
  // EXEC; branches look at z here, after the previous instruction's flag load.
  always_comb begin
    next_state = state;
    we3        = 1'b0;
    wd3_src    = 1'b0;
    z_load     = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    illegal    = 1'b0;
    case (state)
      IDLE: next_state = FETCH;
      FETCH: begin
        if (imem.imem_ready) begin
          next_state = DECODE;
        end else if (miss_cnt == TIMEOUT_LAST) begin
          next_state = FAULT;
        end
      end
      DECODE: next_state = EXEC;
      EXEC: begin
        next_state = FETCH;
        casez (opcode)
          4'b0???: begin
            we3    = 1'b1;
            z_load = 1'b1;
            pc_we  = 1'b1;
          end
          4'b1000: pc_we = 1'b1;
          4'b1001: begin
            we3     = 1'b1;
            wd3_src = 1'b1;
            pc_we   = 1'b1;
          end
          4'b1010: begin
            pc_we  = 1'b1;
            pc_src = 2'd1;
          end
          4'b1011: begin
            pc_we  = 1'b1;
            pc_src = z ? 2'd1 : 2'd0;
          end
          4'b1100: begin
            pc_we  = 1'b1;
            pc_src = z ? 2'd0 : 2'd1;
          end
          4'b1101: next_state = HALT;
          default: begin
            pc_we   = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      HALT:    next_state = HALT;
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Drives the fetch
// interface and z on falling edges and samples outputs there, away from the
// rising edge that updates the control unit.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic       z;
  logic [3:0] ra1;
  logic [3:0] ra2;
  logic [3:0] wa3;
  logic [7:0] imm;
  logic [9:0] target;
  logic [2:0] alu_op;
  logic       we3;
  logic       wd3_src;
  logic       z_load;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       halted;
  logic       fault;
  logic       illegal;

  int tests_run    = 0;
  int tests_failed = 0;
  int we3_pulses   = 0;
  int pulses_before;

  multicycle_ctrl_if imem_bus ();

  multicycle_ctrl #(
    .PC_WIDTH      (10),
    .FETCH_TIMEOUT (15)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .imem    (imem_bus),
    .z       (z),
    .ra1     (ra1),
    .ra2     (ra2),
    .wa3     (wa3),
    .imm     (imm),
    .target  (target),
    .alu_op  (alu_op),
    .we3     (we3),
    .wd3_src (wd3_src),
    .z_load  (z_load),
    .pc_we   (pc_we),
    .pc_src  (pc_src),
    .halted  (halted),
    .fault   (fault),
    .illegal (illegal)
  );

  // Packed views so one comparison covers a whole group of outputs.
  logic [6:0]  strobes;
  logic [42:0] all_outputs;
  assign strobes     = {we3, wd3_src, z_load, pc_we, pc_src, illegal};
  assign all_outputs = {imem_bus.imem_req, ra1, ra2, wa3, imm, target, alu_op,
                        we3, wd3_src, z_load, pc_we, pc_src, halted, fault, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts regfile writes actually seen by the datapath on a rising edge.
  always @(posedge clk) begin
    if (we3) we3_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge while in FETCH: hands over one instruction,
  // then scribbles on instr during DECODE (it must not be captured), and
  // returns at the falling edge inside EXEC.
  task automatic applyStimulus(input logic [15:0] word, input logic zval);
    imem_bus.imem_ready = 1'b1;
    imem_bus.instr      = word;
    z                   = zval;
    @(negedge clk);
    imem_bus.imem_ready = 1'b1;
    imem_bus.instr      = 16'hFFFF;
    checkOutput("decode_strobes", 64'(strobes), 64'd0);
    @(negedge clk);
    imem_bus.imem_ready = 1'b0;
  endtask

  initial begin
    reset               = 1'b0;
    z                   = 1'b0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.instr      = 16'h0000;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", 64'(all_outputs), 64'd0);

    // Release: the first edge goes IDLE->FETCH without any request beforehand.
    reset = 1'b1;
    #1 checkOutput("idle_no_req", 64'(imem_bus.imem_req), 64'd0);
    @(negedge clk);
    checkOutput("fetch_req", 64'(imem_bus.imem_req), 64'd1);

    // ALU add r3 = r2 + r1
    applyStimulus(16'h1321, 1'b0);
    checkOutput("alu_strobes", 64'(strobes), 64'b1011000);
    checkOutput("alu_fields", 64'({wa3, ra1, ra2, alu_op}), 64'({4'd3, 4'd2, 4'd1, 3'd1}));
    checkOutput("alu_no_req", 64'(imem_bus.imem_req), 64'd0);
    @(negedge clk);
    checkOutput("alu_refetch", 64'(imem_bus.imem_req), 64'd1);

    // LI r10 = 0x5C
    applyStimulus(16'h9A5C, 1'b0);
    checkOutput("li_strobes", 64'(strobes), 64'b1101000);
    checkOutput("li_fields", 64'({imm, wa3}), 64'({8'h5C, 4'hA}));
    @(negedge clk);

    // JZ taken and not taken
    applyStimulus(16'hB0F3, 1'b1);
    checkOutput("jz_taken", 64'(strobes), 64'b0001010);
    checkOutput("jz_target", 64'(target), 64'h0F3);
    @(negedge clk);
    applyStimulus(16'hB0F3, 1'b0);
    checkOutput("jz_not_taken", 64'(strobes), 64'b0001000);
    @(negedge clk);

    // JNZ with z=0 takes the branch; with z=1 falls through
    applyStimulus(16'hC0F3, 1'b0);
    checkOutput("jnz_taken", 64'(strobes), 64'b0001010);
    @(negedge clk);
    applyStimulus(16'hC0F3, 1'b1);
    checkOutput("jnz_not_taken", 64'(strobes), 64'b0001000);
    @(negedge clk);

    // Unconditional jump
    applyStimulus(16'hA2AB, 1'b0);
    checkOutput("j_strobes", 64'(strobes), 64'b0001010);
    checkOutput("j_target", 64'(target), 64'h2AB);
    @(negedge clk);

    // NOP and illegal opcode
    applyStimulus(16'h8000, 1'b0);
    checkOutput("nop_strobes", 64'(strobes), 64'b0001000);
    @(negedge clk);
    applyStimulus(16'hE123, 1'b0);
    checkOutput("illegal_strobes", 64'(strobes), 64'b0001001);
    @(negedge clk);
    checkOutput("illegal_one_cycle", 64'(illegal), 64'd0);

    // HALT is absorbing even with ready held high
    applyStimulus(16'hD000, 1'b0);
    checkOutput("halt_exec_strobes", 64'(strobes), 64'd0);
    imem_bus.imem_ready = 1'b1;
    @(negedge clk);
    checkOutput("halted", 64'({halted, imem_bus.imem_req}), 64'b10);
    repeat (3) @(negedge clk);
    checkOutput("halted_stays", 64'({halted, imem_bus.imem_req, strobes}), 64'({2'b10, 7'd0}));

    // Reset in DECODE of an ALU instruction drops the pending write
    reset = 1'b0;
    #1 checkOutput("halt_reset", 64'(all_outputs), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("refetch_after_halt", 64'(imem_bus.imem_req), 64'd1);
    imem_bus.instr = 16'h1321;
    @(negedge clk);
    imem_bus.imem_ready = 1'b0;
    pulses_before = we3_pulses;
    reset = 1'b0;
    #1 checkOutput("decode_reset", 64'(all_outputs), 64'd0);
    repeat (2) @(negedge clk);
    checkOutput("no_we3_pulse", 64'(we3_pulses - pulses_before), 64'd0);
    reset = 1'b1;
    #1 checkOutput("restart_idle", 64'(imem_bus.imem_req), 64'd0);
    @(negedge clk);
    checkOutput("restart_fetch", 64'(imem_bus.imem_req), 64'd1);

    // Fetch timeout: 15 misses lead to FAULT, the 14th does not
    repeat (14) @(negedge clk);
    checkOutput("pre_timeout", 64'({fault, imem_bus.imem_req}), 64'b01);
    @(negedge clk);
    checkOutput("timeout_fault", 64'({fault, imem_bus.imem_req}), 64'b10);
    imem_bus.imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("fault_stays", 64'({fault, imem_bus.imem_req, strobes}), 64'({2'b10, 7'd0}));
    reset = 1'b0;
    #1 checkOutput("fault_reset", 64'(all_outputs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
